dot_matrix_row_scanner: RTL

//  Row-scan engine for the 8x8 dot-matrix display; sits directly downstream of the frequency divider.

---
 rtl/dot_matrix_pkg.sv | 25 ++
 rtl/dot_matrix_row_scanner_edge_tick.sv | 30 +++
 rtl/dot_matrix_row_scanner.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dot_matrix_pkg.sv
// ----------------------------------------------------------------------------
// dot_matrix_pkg
//   Shared definitions for the 8x8 dot-matrix display path.
//   - ROWS_DEF / COLS_DEF / BLANK_CYCLES_DEF : default geometry and blanking
//   - scan_state_t                           : row-scan FSM state encoding
//   - row_aw()                               : row address width for N rows
// ----------------------------------------------------------------------------
package dot_matrix_pkg;

    localparam int ROWS_DEF         = 8;
    localparam int COLS_DEF         = 8;
    localparam int BLANK_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    // Address width for a row index; never narrower than one bit.
    function automatic int row_aw(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/dot_matrix_row_scanner_edge_tick.sv
// ----------------------------------------------------------------------------
// edge_tick
//   Registered rising-edge detector. Turns a slow level (e.g. a divided clock)
//   into a single clk-wide tick, one clk after the rise is first sampled.
//   Ports:
//     clk  in  system clock
//     rst  in  asynchronous, active-low reset
//     sig  in  slow input level (already synchronous to clk)
//     tick out one-cycle pulse per rising edge of sig
// ----------------------------------------------------------------------------
module edge_tick (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic tick
);

    logic sig_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_d <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sig_d <= sig;
            tick  <= sig & ~sig_d;
        end
    end

endmodule

// File: rtl/dot_matrix_row_scanner.sv
// ----------------------------------------------------------------------------
// dot_matrix_row_scanner
//   Row-scan engine for the dot-matrix display. Each rising edge of scan_clk
//   (the divided clock, sampled in the clk domain) advances one row. The frame
//   image is double-buffered: writes land in the back buffer, and a requested
//   swap only takes effect when row 0 is about to be driven, so a frame is
//   never shown half old / half new.
//
//   Optional build macro: DOT_SCAN_BLANK_EN
//     Defined   -> each row change inserts BLANK_CYCLES clk cycles of all-off
//                  output; ticks arriving while blanking are dropped.
//     Undefined -> row changes directly on the tick.
//
//   Ports:
//     clk, rst     system clock, asynchronous active-low reset
//     scan_clk     divided clock; each rising edge is one scan tick
//     wr_en/wr_row/wr_data  write one row image into the back buffer
//     swap_req     request a front/back swap at the next frame boundary
//     swap_ack     one-cycle pulse when the swap happens
//     row_sel      one-hot active-high row enable
//     col_data     column data for the selected row
//     frame_start  one-cycle pulse when row 0 is driven
// ----------------------------------------------------------------------------
module dot_matrix_row_scanner
    import dot_matrix_pkg::*;
#(
    parameter int ROWS         = ROWS_DEF,
    parameter int COLS         = COLS_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scan_clk,
    input  logic                      wr_en,
    input  logic [row_aw(ROWS)-1:0]   wr_row,
    input  logic [COLS-1:0]           wr_data,
    input  logic                      swap_req,
    output logic                      swap_ack,
    output logic [ROWS-1:0]           row_sel,
    output logic [COLS-1:0]           col_data,
    output logic                      frame_start
);

    localparam int                RAW      = row_aw(ROWS);
    localparam logic [RAW-1:0]    LAST_ROW = RAW'(ROWS - 1);
    localparam logic [RAW:0]      ROWS_W   = (RAW + 1)'(ROWS);
    localparam logic [ROWS-1:0]   ROW_ONE  = ROWS'(1);

    scan_state_t state, state_nxt;

    logic                              tick;
    logic [1:0][ROWS-1:0][COLS-1:0]    fbuf;
    logic                              front;
    logic                              back;
    logic                              pending;
    logic [RAW-1:0]                    row_idx;
    logic [RAW-1:0]                    row_inc;
    logic [RAW-1:0]                    nr;
    logic                              drive;
    logic                              blank_enter;
    logic                              do_swap;
    logic                              new_front;
    logic                              wr_ok;
    logic [COLS-1:0]                   col_next;

`ifdef DOT_SCAN_BLANK_EN
    localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    logic [BCW-1:0] blank_cnt;
`endif

    edge_tick u_tick (
        .clk  (clk),
        .rst  (rst),
        .sig  (scan_clk),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (tick) state_nxt = SCAN;
`ifdef DOT_SCAN_BLANK_EN
            SCAN:  if (tick) state_nxt = BLANK;
            BLANK: if (blank_cnt == '0) state_nxt = SCAN;
`else
            SCAN: ;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (row-load strobe, next row index, blank entry)
    // ------------------------------------------------------------------
    assign row_inc = (row_idx == LAST_ROW) ? '0 : row_idx + RAW'(1);

    always_comb begin
        drive       = 1'b0;
        blank_enter = 1'b0;
        nr          = row_idx;
        case (state)
            // First tick after reset always starts a frame at row 0.
            IDLE: if (tick) begin
                drive = 1'b1;
                nr    = '0;
            end
            SCAN: if (tick) begin
`ifdef DOT_SCAN_BLANK_EN
                blank_enter = 1'b1;
`else
                drive = 1'b1;
                nr    = row_inc;
`endif
            end
`ifdef DOT_SCAN_BLANK_EN
            // row_idx still holds the previous row while blanking.
            BLANK: if (blank_cnt == '0) begin
                drive = 1'b1;
                nr    = row_inc;
            end
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame buffer swap and write path
    // ------------------------------------------------------------------
    assign back      = ~front;
    assign wr_ok     = wr_en && ({1'b0, wr_row} < ROWS_W);
    assign do_swap   = drive && (nr == '0) && pending;
    assign new_front = front ^ do_swap;

    // On a swap edge the buffer being written is the one about to become
    // front, so a same-edge write to the row being loaded is forwarded.
    assign col_next = (do_swap && wr_ok && (wr_row == nr)) ? wr_data
                                                          : fbuf[new_front][nr];

    // Writes always target the pre-swap back buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       fbuf             <= '0;
        else if (wr_ok) fbuf[back][wr_row] <= wr_data;
    end

    // ------------------------------------------------------------------
    // Scan datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_idx     <= '0;
            row_sel     <= '0;
            col_data    <= '0;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            front       <= 1'b0;
            pending     <= 1'b0;
        end else begin
            frame_start <= drive && (nr == '0);
            swap_ack    <= do_swap;
            front       <= new_front;
            // A request landing on the swap edge is absorbed by that swap.
            pending     <= do_swap ? 1'b0 : (pending | swap_req);
            if (drive) begin
                row_idx  <= nr;
                row_sel  <= ROW_ONE << nr;
                col_data <= col_next;
            end else if (blank_enter) begin
                row_sel  <= '0;
                col_data <= '0;
            end
        end
    end

`ifdef DOT_SCAN_BLANK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   blank_cnt <= '0;
        else if (blank_enter)                       blank_cnt <= BCW'(BLANK_CYCLES - 1);
        else if (state == BLANK && blank_cnt != '0) blank_cnt <= blank_cnt - BCW'(1);
    end
`endif

endmodule
